// File: rtl/sram_sp_be_ctrl_if.sv
// Request/response bundle between a client engine and sram_sp_be_ctrl.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high; payload is held stable while valid & !ready.
interface sram_sp_be_ctrl_if #(
  parameter int ADR_WD = 5,
  parameter int DAT_WD = 8,
  parameter int COL_WD = 8
);
  localparam int CL_NUM = DAT_WD / COL_WD;

  logic              req_val;
  logic              req_rdy;
  logic              req_wr;
  logic [ADR_WD-1:0] req_adr;
  logic [CL_NUM-1:0] req_msk;
  logic [DAT_WD-1:0] req_dat;
  logic              rsp_val;
  logic              rsp_rdy;
  logic [DAT_WD-1:0] rsp_dat;

  modport master (
    output req_val, req_wr, req_adr, req_msk, req_dat, rsp_rdy,
    input  req_rdy, rsp_val, rsp_dat
  );

  modport slave (
    input  req_val, req_wr, req_adr, req_msk, req_dat, rsp_rdy,
    output req_rdy, rsp_val, rsp_dat
  );
endinterface

// File: rtl/sram_sp_be_ctrl.sv
// Single-port column-enabled SRAM controller with in-order 2-entry read response buffer.
// Optional post-reset zero sweep of the whole array is built when SRAM_CTRL_CLR_EN is defined.
module sram_sp_be_ctrl #(
  parameter  int ADR_WD = 5,
  parameter  int DAT_WD = 8,
  parameter  int COL_WD = 8,
  localparam int CL_NUM = DAT_WD / COL_WD
) (
  input  logic              clk,
  input  logic              rst,
  sram_sp_be_ctrl_if.slave  bus,
  output logic              busy,
  output logic              dbg_state,
  output logic [ADR_WD-1:0] sram_adr,
  output logic [CL_NUM-1:0] sram_wr_ena,
  output logic [DAT_WD-1:0] sram_wr_dat,
  output logic              sram_rd_ena,
  input  logic [DAT_WD-1:0] sram_rd_dat
);

  typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [DAT_WD-1:0] buf_q [2];
  logic              rd_ptr_q, wr_ptr_q, inflight_q;
  logic [1:0]        cnt_q;
  logic              run, pop, push, rd_credit, req_rdy, rd_fire, wr_fire;
  logic [2:0]        occ;
`ifdef SRAM_CTRL_CLR_EN
  logic [ADR_WD-1:0] clr_adr_q, clr_adr_d;
`endif

  // Read credit counts buffered data, the read in flight, and a head leaving this cycle.
  always_comb begin
    run       = (state_q == ST_RUN) && !rst;
    pop       = (cnt_q != 2'd0) && bus.rsp_rdy;
    push      = inflight_q;
    occ       = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    rd_credit = (occ < 3'd2);
    req_rdy   = run && (bus.req_wr || rd_credit);
    wr_fire   = bus.req_val && req_rdy && bus.req_wr;
    rd_fire   = bus.req_val && req_rdy && !bus.req_wr;
  end

  always_comb begin
    sram_adr    = bus.req_adr;
    sram_wr_ena = '0;
    sram_wr_dat = '0;
    sram_rd_ena = 1'b0;
    state_d     = state_q;
    if (wr_fire) begin
      sram_wr_ena = bus.req_msk;
      sram_wr_dat = bus.req_dat;
    end
    if (rd_fire) sram_rd_ena = 1'b1;
`ifdef SRAM_CTRL_CLR_EN
    clr_adr_d = clr_adr_q;
    if (state_q == ST_CLR && !rst) begin
      sram_adr    = clr_adr_q;
      sram_wr_ena = '1;
      clr_adr_d   = clr_adr_q + 1'b1;
      if (clr_adr_q == {ADR_WD{1'b1}}) state_d = ST_RUN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_CTRL_CLR_EN
      state_q   <= ST_CLR;
      clr_adr_q <= '0;
`else
      state_q   <= ST_RUN;
`endif
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q <= state_d;
`ifdef SRAM_CTRL_CLR_EN
      clr_adr_q <= clr_adr_d;
`endif
      inflight_q <= rd_fire;
      if (push) buf_q[wr_ptr_q] <= sram_rd_dat;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.req_rdy = req_rdy;
  assign bus.rsp_val = (cnt_q != 2'd0);
  assign bus.rsp_dat = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : '0;
  assign busy        = (state_q == ST_CLR) && !rst;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_sp_be_ctrl.sv
// Directed bench for sram_sp_be_ctrl (32-bit data, 8-bit columns) with a behavioural SRAM.
// Builds with or without SRAM_CTRL_CLR_EN; the clear-sweep checks follow the macro.
module tb_sram_sp_be_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int CN = DW / CW;
`ifdef SRAM_CTRL_CLR_EN
  localparam logic [DW-1:0] MEM_INIT = 32'hDEADBEEF;
`else
  localparam logic [DW-1:0] MEM_INIT = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_fill = 1'b1;
  logic          busy, dbg_state, sram_rd_ena;
  logic [AW-1:0] sram_adr;
  logic [CN-1:0] sram_wr_ena;
  logic [DW-1:0] sram_wr_dat, sram_rd_dat;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] exp_q [$];
  int            pop_cyc [$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  sram_sp_be_ctrl_if #(.ADR_WD(AW), .DAT_WD(DW), .COL_WD(CW)) bus ();

  sram_sp_be_ctrl #(.ADR_WD(AW), .DAT_WD(DW), .COL_WD(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state(dbg_state),
    .sram_adr(sram_adr), .sram_wr_ena(sram_wr_ena), .sram_wr_dat(sram_wr_dat),
    .sram_rd_ena(sram_rd_ena), .sram_rd_dat(sram_rd_dat)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SRAM: column writes, 1-cycle read, zero output when not reading
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= MEM_INIT;
    end else begin
      for (int c = 0; c < CN; c++)
        if (sram_wr_ena[c]) mem[sram_adr][c*CW +: CW] <= sram_wr_dat[c*CW +: CW];
    end
    rd_q <= sram_rd_ena ? mem[sram_adr] : '0;
  end
  assign sram_rd_dat = rd_q;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted response is compared against the expected queue
  always @(negedge clk) begin
    if (!rst && bus.rsp_val && bus.rsp_rdy) begin
      if (exp_q.size() == 0) check("rsp_unexpected", bus.rsp_dat, 'x);
      else check("rsp_dat", bus.rsp_dat, exp_q.pop_front());
      pop_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [CN-1:0] m,
                       input logic [DW-1:0] d, input bit want, input logic [DW-1:0] e);
    int n = 0;
    bus.req_val = 1'b1; bus.req_wr = wr; bus.req_adr = a; bus.req_msk = m; bus.req_dat = d;
    #1;
    while (!bus.req_rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("req_timeout", {31'b0, bus.req_rdy}, 1);
    else begin
      @(posedge clk);
      if (want) exp_q.push_back(e);
      #1;
    end
    bus.req_val = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(tag, {31'b0, busy}, 0);
  endtask

  initial begin
    int n;
    bus.req_val = 0; bus.req_wr = 1; bus.req_adr = 0; bus.req_msk = 0; bus.req_dat = 0;
    bus.rsp_rdy = 1;
    @(posedge clk); #1;
    mem_fill = 1'b0;
    bus.req_val = 1; bus.req_msk = '1; bus.req_dat = 32'h12345678;
    #1;
    check("rst_req_rdy", {31'b0, bus.req_rdy}, 0);
    check("rst_rsp_val", {31'b0, bus.rsp_val}, 0);
    check("rst_rsp_dat", bus.rsp_dat, 0);
    check("rst_wr_ena", {28'b0, sram_wr_ena}, 0);
    check("rst_rd_ena", {31'b0, sram_rd_ena}, 0);
    bus.req_val = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
`ifdef SRAM_CTRL_CLR_EN
    n = 0;
    while (busy && n < 100) begin
      check("clr_req_rdy", {31'b0, bus.req_rdy}, 0);
      n++;
      @(posedge clk); #1;
    end
    check("clr_busy_cycles", n, 32);
    check("clr_req_rdy_after", {31'b0, bus.req_rdy}, 1);
    issue(0, 5'd17, '0, '0, 1, 32'h0);
    issue(0, 5'd0, '0, '0, 1, 32'h0);
    idle(3);
`else
    bus.req_wr = 0;
    #1;
    check("norst_busy", {31'b0, busy}, 0);
    check("norst_req_rdy", {31'b0, bus.req_rdy}, 1);
    check("norst_state", {31'b0, dbg_state}, 1);
`endif

    // single write then read, exact two-cycle latency
    bus.req_val = 1; bus.req_wr = 1; bus.req_adr = 3; bus.req_msk = 4'b0001; bus.req_dat = 32'h000000A5;
    #1;
    check("wr_strobe_ena", {28'b0, sram_wr_ena}, 32'h1);
    check("wr_strobe_dat", sram_wr_dat, 32'hA5);
    check("wr_strobe_adr", {27'b0, sram_adr}, 3);
    bus.req_val = 0;
    issue(1, 5'd3, 4'b0001, 32'h000000A5, 0, 0);
    issue(0, 5'd3, '0, '0, 1, 32'h000000A5);
    check("lat_n1_rsp_val", {31'b0, bus.rsp_val}, 0);
    idle(1);
    check("lat_n2_rsp_val", {31'b0, bus.rsp_val}, 1);
    check("lat_n2_rsp_dat", bus.rsp_dat, 32'h000000A5);
    idle(2);

    // column masking
    issue(1, 5'd7, 4'b1111, 32'h11223344, 0, 0);
    issue(1, 5'd7, 4'b0101, 32'hFFFFFFFF, 0, 0);
    issue(0, 5'd7, '0, '0, 1, 32'h11FF33FF);
    // empty mask is a no-op; read directly after write sees new data
    issue(1, 5'd7, 4'b0000, 32'h00000000, 0, 0);
    issue(0, 5'd7, '0, '0, 1, 32'h11FF33FF);
    issue(1, 5'd9, 4'b1111, 32'hCAFEF00D, 0, 0);
    issue(0, 5'd9, '0, '0, 1, 32'hCAFEF00D);
    idle(3);

    // 8 back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) issue(1, AW'(8 + i), 4'b1111, 32'hC0DE0000 + i, 0, 0);
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) issue(0, AW'(8 + i), '0, '0, 1, 32'hC0DE0000 + i);
    idle(4);
    check("b2b_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) check("b2b_span", pop_cyc[7] - pop_cyc[0], 7);

    // backpressure: two reads fill the buffer, the third waits
    issue(1, 5'd20, 4'b1111, 32'hAAAA0014, 0, 0);
    issue(1, 5'd21, 4'b1111, 32'hAAAA0015, 0, 0);
    issue(1, 5'd22, 4'b1111, 32'hAAAA0016, 0, 0);
    bus.rsp_rdy = 0;
    issue(0, 5'd20, '0, '0, 1, 32'hAAAA0014);
    issue(0, 5'd21, '0, '0, 1, 32'hAAAA0015);
    bus.req_val = 1; bus.req_wr = 0; bus.req_adr = 22;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_rdy", {31'b0, bus.req_rdy}, 0);
      check("bp_rsp_dat", bus.rsp_dat, 32'hAAAA0014);
      @(posedge clk); #1;
    end
    check("bp_rsp_val", {31'b0, bus.rsp_val}, 1);
    bus.rsp_rdy = 1;
    #1;
    check("bp_release_rdy", {31'b0, bus.req_rdy}, 1);
    @(posedge clk);
    exp_q.push_back(32'hAAAA0016);
    #1;
    bus.req_val = 0;
    idle(4);
    check("bp_drained", exp_q.size(), 0);

    // reset right after a read is accepted drops the read
    issue(0, 5'd8, '0, '0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst_mid_rsp_val", {31'b0, bus.rsp_val}, 0);
      @(posedge clk); #1;
    end
    wait_run("rst_mid_busy");
`ifdef SRAM_CTRL_CLR_EN
    issue(0, 5'd8, '0, '0, 1, 32'h0);
`else
    issue(0, 5'd8, '0, '0, 1, 32'hC0DE0000);
`endif
    idle(4);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
